adma_data_fifo: RTL and testbench
=================================

// Module: adma_data_fifo
// PURPOSE
//  Synchronous data FIFO between the ADMA engine and the SD data-line serializer/deserializer.
//  - DMA side writes words fetched from RAM (host->card).
//  - DMA side reads words the card side has deposited (card->host).
//  - Drives fifo_full/fifo_empty back to the ADMA state machine for flow control.
//  - Reports sticky overflow/underflow errors for the ADMA error status register.
// PARAMETERS
//  DATA_WIDTH           32  word width, matches ADMA data bus
//  ADDR_WIDTH           3   log2(depth); depth = 2**ADDR_WIDTH = 8
//  ALMOST_FULL_THRESH   6   almost_full asserted when word_count >= value (ADMA_FIFO_ALMOST_EN only)
//  ALMOST_EMPTY_THRESH  2   almost_empty asserted when word_count <= value (ADMA_FIFO_ALMOST_EN only)
// PORTS
//  CLK           in   1             single clock, all logic on rising edge
//  RESET         in   1             synchronous, active-high
//  flush         in   1             synchronous clear of contents (block gap stop / abort)
//  clear_errors  in   1             clears overflow/underflow sticky flags
//  data_in       in   DATA_WIDTH    write data
//  fifo_write    in   1             write request
//  fifo_read     in   1             read request
//  data_out      out  DATA_WIDTH    registered read data
//  fifo_full     out  1             word_count == 2**ADDR_WIDTH
//  fifo_empty    out  1             word_count == 0
//  word_count    out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
//  overflow      out  1             sticky: write attempted while full and not accepted
//  underflow     out  1             sticky: read attempted while empty
//  almost_full   out  1             present only with ADMA_FIFO_ALMOST_EN
//  almost_empty  out  1             present only with ADMA_FIFO_ALMOST_EN
// BEHAVIOUR
//  - Reset (RESET=1 at edge): wr_ptr=rd_ptr=0, word_count=0, data_out=0, overflow=underflow=0.
//    Result: fifo_empty=1, fifo_full=0. Storage array is not cleared.
//  - Priority each edge: RESET > flush > read/write.
//    - flush: pointers and count go to 0, data_out goes to 0.
//    - flush does not touch the error flags; clear_errors does.
//  - Pointers: ADDR_WIDTH bits, wrap naturally at 2**ADDR_WIDTH-1 -> 0.
//    word_count carries the extra bit that separates full from empty.
//  - rd_acc = fifo_read & ~fifo_empty.
//  - wr_acc = fifo_write & (~fifo_full | rd_acc).
//    A write while full is accepted only when a read is accepted in the same cycle.
//  - Flags and word_count are registered from current-cycle state. No bypass:
//    - Write to an empty FIFO: fifo_empty deasserts the next cycle.
//    - A simultaneous read on an empty FIFO is rejected and counts as underflow.
//  - Read latency 1: on rd_acc, data_out <= mem[rd_ptr] and rd_ptr increments.
//    data_out holds its value when no read is accepted.
//  - word_count update:
//    - +1 on wr_acc only.
//    - -1 on rd_acc only.
//    - unchanged when both or neither are accepted.
//  - Error flags:
//    - overflow <= 1 on fifo_write & ~wr_acc.
//    - underflow <= 1 on fifo_read & fifo_empty.
//    - clear_errors clears both flags. If set and clear occur in the same cycle, set wins.
//  - Reset or flush mid-burst discards all pending words. The ADMA side must restart the block.
// CONFIGURATION
//  ADMA_FIFO_ALMOST_EN defined:
//    - almost_full/almost_empty ports exist.
//    - They are registered and computed from the next-state word_count, so they track word_count exactly.
//    - Reset values: almost_full=0, almost_empty=1.
//  ADMA_FIFO_ALMOST_EN undefined:
//    - The ports and their logic are omitted entirely.
//    - All other behaviour is identical.
// TESTING
//  1. Reset, then write 0x11111111..0x88888888 (8 words).
//     -> fifo_full=1 and word_count=8 one cycle after the last write; overflow=0.
//  2. Full FIFO, fifo_write=1 with 0xDEADBEEF and no read.
//     -> overflow=1, word_count stays 8.
//     -> Subsequent reads return 0x11111111 first; 0xDEADBEEF is never read.
//  3. Full FIFO, simultaneous read and write of 0xA5A5A5A5.
//     -> data_out=0x11111111, word_count stays 8.
//     -> After 7 more reads, the 8th read returns 0xA5A5A5A5 (pointer wrap).
//  4. Empty FIFO, fifo_read=1.
//     -> underflow=1, data_out unchanged.
//     -> clear_errors=1 for one cycle -> underflow=0.
//  5. 5 words stored, flush=1 with fifo_write=1 in the same cycle.
//     -> Next cycle word_count=0, fifo_empty=1, data_out=0; the write is discarded.
//  6. ADMA_FIFO_ALMOST_EN defined, write 6 words.
//     -> almost_empty falls after the 3rd write; almost_full rises after the 6th write.
//     -> Read 4 words -> almost_full=0, almost_empty=1.

Source files
------------

// File: rtl/adma_data_fifo.sv
// adma_data_fifo: synchronous ADMA<->SD data FIFO with sticky overflow/underflow flags (optional almost flags via ADMA_FIFO_ALMOST_EN)
module adma_data_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
`ifdef ADMA_FIFO_ALMOST_EN
  ,
  parameter int ALMOST_FULL_THRESH  = 6,
  parameter int ALMOST_EMPTY_THRESH = 2
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic                  clear_errors,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_write,
  input  logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
`ifdef ADMA_FIFO_ALMOST_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic                  w_rd_acc, w_wr_acc;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  assign w_rd_acc = fifo_read & ~fifo_empty;
  assign w_wr_acc = fifo_write & (~fifo_full | w_rd_acc);
  // Next occupancy; flags are registered from it so they never lag word_count
  always_comb
    w_count_nxt = flush ? '0 :
                  (w_wr_acc && !w_rd_acc) ? word_count + 1'b1 :
                  (w_rd_acc && !w_wr_acc) ? word_count - 1'b1 : word_count;
  // Storage array, deliberately not reset; flush blocks the write so a discarded word never lands
  always_ff @(posedge CLK)
    if (!RESET && !flush && w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  // Pointers, occupancy, status flags and registered read data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      word_count <= '0;
      data_out   <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        data_out <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_acc) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          data_out <= r_mem[r_rd_ptr];
        end
      end
      word_count <= w_count_nxt;
      fifo_full  <= w_count_nxt == DEPTH;
      fifo_empty <= w_count_nxt == '0;
      overflow   <= (fifo_write & ~w_wr_acc) | (overflow & ~clear_errors);
      underflow  <= (fifo_read & fifo_empty) | (underflow & ~clear_errors);
    end
  end
`ifdef ADMA_FIFO_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = ALMOST_FULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT = ALMOST_EMPTY_THRESH[ADDR_WIDTH:0];
  // Threshold flags from next occupancy so they change on the same edge as word_count
  always_ff @(posedge CLK) begin
    if (RESET) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= w_count_nxt >= AF_CNT;
      almost_empty <= w_count_nxt <= AE_CNT;
    end
  end
`endif
endmodule

// File: tb/tb_adma_data_fifo.sv
// tb_adma_data_fifo: directed self-checking bench for adma_data_fifo (almost-flag steps built when ADMA_FIFO_ALMOST_EN is defined)
module tb_adma_data_fifo;
  logic        CLK = 1'b0;
  logic        RESET, flush, clear_errors, fifo_write, fifo_read;
  logic [31:0] data_in, data_out;
  logic        fifo_full, fifo_empty, overflow, underflow;
  logic [3:0]  word_count;
`ifdef ADMA_FIFO_ALMOST_EN
  logic        almost_full, almost_empty;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  adma_data_fifo dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .clear_errors(clear_errors),
    .data_in(data_in), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .word_count(word_count), .overflow(overflow),
`ifdef ADMA_FIFO_ALMOST_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    fifo_write = 1'b1;
    data_in    = d;
    step();
    fifo_write = 1'b0;
  endtask

  task automatic rd();
    fifo_read = 1'b1;
    step();
    fifo_read = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; flush = 1'b0; clear_errors = 1'b0;
    fifo_write = 1'b0; fifo_read = 1'b0; data_in = '0;
    step();
    step();
    RESET = 1'b0;
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`ifdef ADMA_FIFO_ALMOST_EN
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
    // fill with 0x11111111..0x88888888
    wr(32'h11111111);
    chk("w1_empty", 32'(fifo_empty), 32'd0);
    chk("w1_count", 32'(word_count), 32'd1);
    for (int i = 2; i <= 8; i++) wr(32'h11111111 * i);
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_count", 32'(word_count), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd0);
    // write into a full FIFO without a read is rejected
    wr(32'hDEADBEEF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(word_count), 32'd8);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    // simultaneous read and write while full
    fifo_read = 1'b1;
    wr(32'hA5A5A5A5);
    fifo_read = 1'b0;
    chk("rw_dout", data_out, 32'h11111111);
    chk("rw_count", 32'(word_count), 32'd8);
    chk("rw_full", 32'(fifo_full), 32'd1);
    chk("rw_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      rd();
      chk($sformatf("drain%0d", i), data_out, 32'h11111111 * i);
    end
    rd();
    chk("wrap_dout", data_out, 32'hA5A5A5A5);
    chk("drain_count", 32'(word_count), 32'd0);
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    // read on empty
    rd();
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_dout", data_out, 32'hA5A5A5A5);
    chk("unf_count", 32'(word_count), 32'd0);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    chk("unf_clr", 32'(underflow), 32'd0);
    // set beats clear in the same cycle
    clear_errors = 1'b1;
    rd();
    clear_errors = 1'b0;
    chk("unf_setwins", 32'(underflow), 32'd1);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    chk("unf_clr2", 32'(underflow), 32'd0);
    // flush with concurrent write
    for (int i = 0; i < 5; i++) wr(32'h100 + i);
    chk("pre_flush_count", 32'(word_count), 32'd5);
    flush = 1'b1;
    wr(32'h00000BAD);
    flush = 1'b0;
    chk("flush_count", 32'(word_count), 32'd0);
    chk("flush_empty", 32'(fifo_empty), 32'd1);
    chk("flush_dout", data_out, 32'd0);
    wr(32'h77777777);
    chk("post_flush_count", 32'(word_count), 32'd1);
    rd();
    chk("post_flush_dout", data_out, 32'h77777777);
    chk("post_flush_empty", 32'(fifo_empty), 32'd1);
`ifdef ADMA_FIFO_ALMOST_EN
    for (int i = 1; i <= 6; i++) begin
      wr(32'h200 + i);
      chk($sformatf("ae_w%0d", i), 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("af_w%0d", i), 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) rd();
    chk("af_r4", 32'(almost_full), 32'd0);
    chk("ae_r4", 32'(almost_empty), 32'd1);
    chk("cnt_r4", 32'(word_count), 32'd2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
